// File: rtl/dmem_responder.sv
// Data-memory responder for the M-stage bus: word RAM cleared by an init walk after
// every reset, plus an MMIO window holding the LED register and two counters.
module dmem_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int LED_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWriteM,
    input  logic             MemtoRegM,
    input  logic [31:0]      ALUOutM,
    input  logic [31:0]      WriteDataM,
    output logic [31:0]      DmmRD,
    output logic             MemBusy,
    output logic             MisalignErr,
    output logic             RangeErr,
    output logic [LED_W-1:0] Led
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [31:0]         cyc_q, cyc_d;
    logic [31:0]         wr_q, wr_d;
    logic                mis_q, mis_d;
    logic                rng_q, rng_d;
    logic [31:0]         mem_q [DEPTH];

    logic                is_mmio_s;
    logic                in_range_s;
    logic                aligned_s;
    logic                access_s;
    logic                running_s;
    logic                commit_s;
    logic [ADDR_W-1:0]   idx_s;
    logic [15:0]         mmio_off_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [31:0]         mem_wdata_s;

    // Address decode; the MMIO offset drops the byte lane so misaligned reads see the aligned word
    always_comb begin
        is_mmio_s  = (ALUOutM[31:16] == 16'hFFFF);
        in_range_s = !is_mmio_s && (ALUOutM[31:ADDR_W+2] == '0);
        aligned_s  = (ALUOutM[1:0] == 2'b00);
        access_s   = MemWriteM | MemtoRegM;
        running_s  = (state_q == ST_RUN);
        commit_s   = running_s && MemWriteM && aligned_s;
        idx_s      = ALUOutM[ADDR_W+1:2];
        mmio_off_s = {ALUOutM[15:2], 2'b00};
    end

    // Combinational read path
    always_comb begin
        DmmRD = 32'd0;
        if (!running_s) begin
            DmmRD = 32'd0;
        end else if (is_mmio_s) begin
            case (mmio_off_s)
                16'h0000: DmmRD = {{(32-LED_W){1'b0}}, led_q};
                16'h0004: DmmRD = cyc_q;
                16'h0008: DmmRD = wr_q;
                default:  DmmRD = 32'd0;
            endcase
        end else if (in_range_s) begin
            DmmRD = mem_q[idx_s];
        end else begin
            DmmRD = 32'd0;
        end
    end

    // Next-state logic for the FSM, counters, LED and sticky error flags
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        led_d       = led_q;
        cyc_d       = cyc_q;
        wr_d        = wr_q;
        mis_d       = mis_q;
        rng_d       = rng_q;
        mem_we_s    = 1'b0;
        mem_addr_s  = idx_s;
        mem_wdata_s = WriteDataM;
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = ptr_q;
                mem_wdata_s = 32'd0;
                ptr_d       = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_q + 32'd1;
                if (access_s && !aligned_s) begin
                    mis_d = 1'b1;
                end else begin
                    mis_d = mis_q;
                end
                if (access_s && !is_mmio_s && !in_range_s) begin
                    rng_d = 1'b1;
                end else begin
                    rng_d = rng_q;
                end
                if (commit_s && is_mmio_s) begin
                    case (mmio_off_s)
                        16'h0000: led_d = WriteDataM[LED_W-1:0];
                        16'h0008: wr_d  = 32'd0;
                        default:  led_d = led_q;
                    endcase
                end else if (commit_s && in_range_s) begin
                    mem_we_s = 1'b1;
                    if (wr_q != 32'hFFFF_FFFF) begin
                        wr_d = wr_q + 32'd1;
                    end else begin
                        wr_d = wr_q;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // State registers; reset restarts the clearing walk from word 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            led_q   <= '0;
            cyc_q   <= 32'd0;
            wr_q    <= 32'd0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            led_q   <= led_d;
            cyc_q   <= cyc_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
        end
    end

    // Word RAM write port, shared by the init walk and committed stores
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_q[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign MemBusy     = (state_q == ST_INIT);
    assign MisalignErr = mis_q;
    assign RangeErr    = rng_q;
    assign Led         = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized run
// compared against an address-level reference model of memory, MMIO and error flags.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] DmmRD;
    logic        MemBusy;
    logic        MisalignErr;
    logic        RangeErr;
    logic [7:0]  Led;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_mem [256];
    int          m_busy;
    logic [7:0]  m_led;
    logic [31:0] m_cyc;
    logic [31:0] m_wr;
    logic        m_mis;
    logic        m_rng;

    dmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .DmmRD      (DmmRD),
        .MemBusy    (MemBusy),
        .MisalignErr(MisalignErr),
        .RangeErr   (RangeErr),
        .Led        (Led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned widx;
        if (m_busy > 0) return 32'd0;
        if (a[31:16] == 16'hFFFF) begin
            if (a[15:2] == 14'd0) return {24'd0, m_led};
            if (a[15:2] == 14'd1) return m_cyc;
            if (a[15:2] == 14'd2) return m_wr;
            return 32'd0;
        end
        widx = a >> 2;
        if (widx < 256) return m_mem[widx];
        return 32'd0;
    endfunction

    // Apply one clock edge to the model using the inputs present before the edge
    task automatic model_edge();
        int unsigned widx;
        logic        mmio;
        widx = ALUOutM >> 2;
        mmio = (ALUOutM[31:16] == 16'hFFFF);
        if (reset) begin
            m_busy = 256;
            m_led  = 8'd0;
            m_cyc  = 32'd0;
            m_wr   = 32'd0;
            m_mis  = 1'b0;
            m_rng  = 1'b0;
            for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
        end else begin
            m_cyc = m_cyc + 32'd1;
            if ((MemWriteM || MemtoRegM) && ALUOutM[1:0] != 2'b00) m_mis = 1'b1;
            if ((MemWriteM || MemtoRegM) && !mmio && widx >= 256) m_rng = 1'b1;
            if (MemWriteM && ALUOutM[1:0] == 2'b00) begin
                if (mmio) begin
                    if (ALUOutM[15:0] == 16'h0000) m_led = WriteDataM[7:0];
                    if (ALUOutM[15:0] == 16'h0008) m_wr = 32'd0;
                end else if (widx < 256) begin
                    m_mem[widx] = WriteDataM;
                    if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 32'd1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic we, input logic ld, input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = we;
        MemtoRegM  = ld;
        ALUOutM    = a;
        WriteDataM = d;
    endtask

    task automatic test_reset();
        int n;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (MemBusy !== 1'b1 || Led !== 8'h00 || MisalignErr !== 1'b0 || RangeErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b led=%h mis=%b rng=%b want 1 00 0 0", MemBusy, Led, MisalignErr, RangeErr);
        end
        n = 0;
        while (MemBusy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL init_length got %0d cycles want 256", n);
        end
        drive(1'b0, 1'b1, 32'h0000_03FC, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'd0) begin
            errors++;
            $display("FAIL read_3fc_after_init got %h want 00000000", DmmRD);
        end
        tick();
    endtask

    task automatic test_store_load();
        drive(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (DmmRD !== 32'd0) begin
            errors++;
            $display("FAIL same_cycle_read got %h want 00000000", DmmRD);
        end
        tick();
        drive(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_after_store got %h want deadbeef", DmmRD);
        end
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'd1) begin
            errors++;
            $display("FAIL wrcnt_one got %h want 00000001", DmmRD);
        end
        tick();
    endtask

    task automatic test_errors();
        drive(1'b1, 1'b0, 32'h0000_0012, 32'h1234_5678);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        #1;
        checks++;
        if (MisalignErr !== 1'b1 || RangeErr !== 1'b0) begin
            errors++;
            $display("FAIL misalign_flag got mis=%b rng=%b want 1 0", MisalignErr, RangeErr);
        end
        checks++;
        if (DmmRD !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL misalign_store_dropped got %h want deadbeef", DmmRD);
        end
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'd1) begin
            errors++;
            $display("FAIL misalign_wrcnt got %h want 00000001", DmmRD);
        end
        drive(1'b0, 1'b1, 32'h0000_0400, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'd0) begin
            errors++;
            $display("FAIL range_read got %h want 00000000", DmmRD);
        end
        tick();
        checks++;
        if (RangeErr !== 1'b1) begin
            errors++;
            $display("FAIL range_flag got %b want 1", RangeErr);
        end
    endtask

    task automatic test_mmio();
        logic [31:0] c0;
        drive(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_01A5);
        tick();
        checks++;
        if (Led !== 8'hA5) begin
            errors++;
            $display("FAIL led_write got %h want a5", Led);
        end
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'h0000_0000);
        tick();
        drive(1'b0, 1'b1, 32'hFFFF_0004, 32'h0);
        #1;
        c0 = m_cyc;
        checks++;
        if (DmmRD !== c0 || c0 == 32'd0) begin
            errors++;
            $display("FAIL cyccnt_ro got %h want %h", DmmRD, c0);
        end
        drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0055);
        tick();
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'd0) begin
            errors++;
            $display("FAIL wrcnt_clear got %h want 00000000", DmmRD);
        end
        drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL led_readback got %h want 000000a5", DmmRD);
        end
        tick();
    endtask

    task automatic test_init_store();
        int n;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D);
        n = 0;
        while (MemBusy === 1'b1 && n < 400) begin
            if (n == 250) drive(1'b0, 1'b0, 32'h0000_0020, 32'h0);
            #1;
            if (n < 250 && DmmRD !== 32'd0) begin
                checks++;
                errors++;
                $display("FAIL init_read_zero got %h want 00000000", DmmRD);
            end
            tick();
            n++;
        end
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'd0) begin
            errors++;
            $display("FAIL init_store_ignored got %h want 00000000", DmmRD);
        end
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'd0) begin
            errors++;
            $display("FAIL init_wrcnt got %h want 00000000", DmmRD);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h1111_2222);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_003C);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0401, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (MemBusy !== 1'b1 || Led !== 8'h00 || MisalignErr !== 1'b0 || RangeErr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state busy=%b led=%h mis=%b rng=%b want 1 00 0 0", MemBusy, Led, MisalignErr, RangeErr);
        end
        n = 0;
        while (MemBusy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL mid_reset_init_length got %0d cycles want 256", n);
        end
        drive(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        #1;
        checks++;
        if (DmmRD !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_data_cleared got %h want 00000000", DmmRD);
        end
        tick();
    endtask

    task automatic test_random();
        int unsigned kind;
        int unsigned widx;
        logic [31:0] a;
        logic [31:0] exp;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                widx = $urandom_range(0, 279);
                a = (widx << 2) | (($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
            end else if (kind < 9) begin
                a = 32'hFFFF_0000 | ($urandom_range(0, 4) * 4);
            end else begin
                a = $urandom & 32'h7FFF_FFFC;
            end
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, $urandom);
            #1;
            exp = model_read(a);
            checks++;
            if (DmmRD !== exp) begin
                errors++;
                $display("FAIL rand_read addr=%h got %h want %h", a, DmmRD, exp);
            end
            tick();
            checks++;
            if (Led !== m_led || MisalignErr !== m_mis || RangeErr !== m_rng || MemBusy !== 1'b0) begin
                errors++;
                $display("FAIL rand_state led=%h mis=%b rng=%b busy=%b want %h %b %b 0", Led, MisalignErr, RangeErr, MemBusy, m_led, m_mis, m_rng);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        m_busy = 256;
        test_reset();
        test_store_load();
        test_errors();
        test_mmio();
        test_init_store();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
